ucsbece154b_ifetch: RTL and testbench

UCSBECE154B_IFETCH -- requirements
Module: ucsbece154b_ifetch

---
 rtl/ucsbece154b_ifetch.sv | 112 +++++++++++
 tb/tb_ucsbece154b_ifetch.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154b_ifetch.sv
// Two-entry instruction fetch buffer with a single-outstanding memory read FSM.
// Serves InstrF on a tag hit and prefetches the next word whenever the current PC already hits.
module ucsbece154b_ifetch #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF_i,
  input  logic        FlushI_i,
  output logic [31:0] InstrF_o,
  output logic        FetchStall_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  valid_q, valid_d;
  logic [29:0] tag_q [2];
  logic [31:0] data_q [2];
  logic [31:0] addr_q, addr_d;
  logic        discard_q, discard_d;

  logic [29:0] pc_tag, next_tag;
  logic [1:0]  tag_match, hit, next_hit;
  logic        fill_en, victim;
  logic        unused_pc_lo;

  assign pc_tag       = PCF_i[31:2];
  assign next_tag     = pc_tag + 30'd1;
  assign unused_pc_lo = ^PCF_i[1:0];

  assign tag_match[0] = (tag_q[0] == pc_tag);
  assign tag_match[1] = (tag_q[1] == pc_tag);
  assign hit          = valid_q & tag_match;
  assign next_hit[0]  = valid_q[0] && (tag_q[0] == next_tag);
  assign next_hit[1]  = valid_q[1] && (tag_q[1] == next_tag);

  // Fill the entry the current PC is not using; entry 0 when the tags do not disambiguate.
  assign victim = tag_match[0] && !tag_match[1];

  assign InstrF_o     = hit[0] ? data_q[0] : (hit[1] ? data_q[1] : NOP_INSTR);
  assign FetchStall_o = ~|hit;
  assign mem_req_o    = (state_q == S_REQ);
  assign mem_addr_o   = addr_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    discard_d = discard_q;
    fill_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!(|hit)) begin
          state_d   = S_REQ;
          addr_d    = {pc_tag, 2'b00};
          discard_d = 1'b0;
        end else if (!(|next_hit)) begin
          state_d   = S_REQ;
          addr_d    = {next_tag, 2'b00};
          discard_d = 1'b0;
        end
      end
      S_REQ: begin
        if (mem_ready_i) state_d = S_WAIT;
        if (FlushI_i) discard_d = 1'b1;
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          state_d   = S_IDLE;
          discard_d = 1'b0;
          fill_en   = !discard_q && !FlushI_i;
        end else if (FlushI_i) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    if (fill_en) valid_d[victim] = 1'b1;
    if (FlushI_i) valid_d = 2'b00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      valid_q   <= 2'b00;
      addr_q    <= '0;
      discard_q <= 1'b0;
      tag_q[0]  <= '0;
      tag_q[1]  <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      discard_q <= discard_d;
      if (fill_en) tag_q[victim] <= addr_q[31:2];
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) data_q[victim] <= mem_rdata_i;
  end

endmodule

// File: tb/tb_ucsbece154b_ifetch.sv
// Bench for ucsbece154b_ifetch: directed scenarios then random traffic, all checked
// against a transaction-level model of the buffer and its one outstanding request.
module tb_ucsbece154b_ifetch;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF_i;
  logic        FlushI_i;
  logic [31:0] InstrF_o;
  logic        FetchStall_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  ucsbece154b_ifetch #(.NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .PCF_i(PCF_i), .FlushI_i(FlushI_i),
    .InstrF_o(InstrF_o), .FetchStall_o(FetchStall_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ready_i(mem_ready_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: buffer contents plus a record of the single outstanding request.
  logic        mv [2];
  logic [29:0] mt [2];
  logic [31:0] md [2];
  bit          busy, acc, stale;
  logic [31:0] raddr;

  // Memory environment.
  bit          rdy_en, rnd_mode, acc_s, rsp_pend;
  logic [31:0] addr_s, rsp_addr;
  int          lat, rsp_cnt;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h00010000) return 32'h00500093;
    return {a[15:0], a[31:16]} ^ 32'h13579BDF;
  endfunction

  function automatic int lookup(input logic [31:0] a);
    for (int k = 0; k < 2; k++)
      if (mv[k] && mt[k] == a[31:2]) return k;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mv[0] = 1'b0; mv[1] = 1'b0;
    mt[0] = '0;   mt[1] = '0;
    busy = 0; acc = 0; stale = 0; raddr = '0;
  endtask

  task automatic model_update();
    int k, n, w;
    bit was_busy;
    logic [31:0] nx;
    nx = PCF_i + 32'd4;
    k = lookup(PCF_i);
    n = lookup(nx);
    was_busy = busy;
    if (busy && acc) begin
      if (mem_rvalid_i) begin
        if (!stale && !FlushI_i) begin
          w = (mt[0] == PCF_i[31:2] && mt[1] != PCF_i[31:2]) ? 1 : 0;
          mv[w] = 1'b1; mt[w] = raddr[31:2]; md[w] = mem_rdata_i;
        end
        busy = 0; acc = 0; stale = 0;
      end
    end else if (busy) begin
      if (mem_ready_i) acc = 1;
    end else if (k < 0) begin
      busy = 1; raddr = {PCF_i[31:2], 2'b00};
    end else if (n < 0) begin
      busy = 1; raddr = {nx[31:2], 2'b00};
    end
    if (FlushI_i && was_busy && busy) stale = 1;
    if (FlushI_i) begin mv[0] = 1'b0; mv[1] = 1'b0; end
  endtask

  task automatic sample();
    int k;
    k = lookup(PCF_i);
    chk("instr", InstrF_o, (k < 0) ? NOP : md[k]);
    chk("stall", 32'(FetchStall_o), (k < 0) ? 32'd1 : 32'd0);
    chk("req", 32'(mem_req_o), 32'(busy && !acc));
    if (busy && !acc) chk("addr", mem_addr_o, raddr);
    acc_s  = mem_req_o && mem_ready_i;
    addr_s = mem_addr_o;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset(); else model_update();
    if (acc_s) begin
      rsp_pend = 1; rsp_addr = addr_s;
      rsp_cnt = rnd_mode ? $urandom_range(1, 3) : lat;
    end
    #1;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    if (rsp_pend) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        mem_rvalid_i = 1'b1; mem_rdata_i = memf(rsp_addr); rsp_pend = 0;
      end
    end
    mem_ready_i = rnd_mode ? ($urandom_range(0, 2) != 0) : rdy_en;
    @(negedge clk);
    sample();
  endtask

  task automatic do_reset();
    reset = 1'b0; model_reset(); acc_s = 0; rsp_pend = 0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1; PCF_i = '0; FlushI_i = 1'b0;
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    rdy_en = 0; rnd_mode = 0; acc_s = 0; rsp_pend = 0; lat = 1; rsp_cnt = 0;
    model_reset();
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_instr", InstrF_o, NOP);
    chk("rst_stall", 32'(FetchStall_o), 32'd1);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    tick(); tick();
    reset = 1'b1;

    // Cold miss, fill, then prefetch of the next word.
    PCF_i = 32'h00010000; rdy_en = 1; lat = 1;
    tick();
    chk("cold_req", 32'(mem_req_o), 32'd1);
    chk("cold_addr", mem_addr_o, 32'h00010000);
    tick();
    tick();
    chk("cold_instr", InstrF_o, 32'h00500093);
    chk("cold_stall", 32'(FetchStall_o), 32'd0);
    rdy_en = 0;
    tick();
    chk("pf_req", 32'(mem_req_o), 32'd1);
    chk("pf_addr", mem_addr_o, 32'h00010004);

    // Backpressure while the PC wanders.
    for (int i = 0; i < 4; i++) begin
      PCF_i = 32'h00010000 + 32'($urandom_range(0, 63)) * 4;
      tick();
      chk("bp_req", 32'(mem_req_o), 32'd1);
      chk("bp_addr", mem_addr_o, 32'h00010004);
    end
    rdy_en = 1; PCF_i = 32'h00010004;
    repeat (4) tick();

    // Redirect while waiting for data.
    do_reset();
    PCF_i = 32'h00010004; lat = 3; rdy_en = 1;
    tick();
    chk("rd_addr0", mem_addr_o, 32'h00010004);
    tick();
    PCF_i = 32'h00010100;
    tick(); tick();
    chk("rd_stall0", 32'(FetchStall_o), 32'd1);
    tick();
    chk("rd_stall1", 32'(FetchStall_o), 32'd1);
    chk("rd_req_idle", 32'(mem_req_o), 32'd0);
    tick();
    chk("rd_req1", 32'(mem_req_o), 32'd1);
    chk("rd_addr1", mem_addr_o, 32'h00010100);
    PCF_i = 32'h00010004;
    tick();
    chk("rd_stale_hit", InstrF_o, memf(32'h00010004));
    repeat (4) tick();

    // Flush while waiting: the response is dropped and the miss is refetched.
    do_reset();
    PCF_i = 32'h00010000; lat = 3; rdy_en = 1;
    tick(); tick();
    FlushI_i = 1'b1;
    tick();
    FlushI_i = 1'b0;
    tick(); tick();
    chk("fl_stall", 32'(FetchStall_o), 32'd1);
    chk("fl_instr", InstrF_o, NOP);
    tick();
    chk("fl_req", 32'(mem_req_o), 32'd1);
    chk("fl_addr", mem_addr_o, 32'h00010000);
    repeat (4) tick();

    // Prefetch address wraps past the top of the address space.
    do_reset();
    PCF_i = 32'hFFFFFFFC; lat = 1; rdy_en = 1;
    tick();
    chk("wr_addr0", mem_addr_o, 32'hFFFFFFFC);
    tick(); tick();
    chk("wr_stall", 32'(FetchStall_o), 32'd0);
    chk("wr_instr", InstrF_o, memf(32'hFFFFFFFC));
    tick();
    chk("wr_req", 32'(mem_req_o), 32'd1);
    chk("wr_addr1", mem_addr_o, 32'h00000000);
    repeat (3) tick();

    // Reset in the middle of a read; the late response must be ignored.
    do_reset();
    PCF_i = 32'h00010000; lat = 4; rdy_en = 1;
    tick(); tick();
    reset = 1'b0; model_reset(); acc_s = 0; rdy_en = 0;
    #1;
    chk("mr_req", 32'(mem_req_o), 32'd0);
    chk("mr_stall", 32'(FetchStall_o), 32'd1);
    tick(); tick(); tick();
    chk("mr_stray_rv", 32'(mem_rvalid_i), 32'd1);
    reset = 1'b1;
    #1;
    chk("mr_rel_req", 32'(mem_req_o), 32'd0);
    chk("mr_rel_stall", 32'(FetchStall_o), 32'd1);
    tick();
    chk("mr_nofill", 32'(FetchStall_o), 32'd1);
    chk("mr_refetch", mem_addr_o, 32'h00010000);

    // Random traffic: sequential fetch on hits, occasional jumps and flushes.
    rnd_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      int r;
      FlushI_i = ($urandom_range(0, 39) == 0);
      r = $urandom_range(0, 15);
      if (r == 0)      PCF_i = 32'h00010000 + 32'($urandom_range(0, 31)) * 4;
      else if (r == 1) PCF_i = 32'hFFFFFFF0 + 32'($urandom_range(0, 3)) * 4;
      else if (lookup(PCF_i) >= 0) PCF_i = PCF_i + 32'd4;
      tick();
    end
    FlushI_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
